// File: rtl/mole_round_controller.sv
// Whack-a-mole round sequencer: paces gap/up phases from tick, picks holes from an LFSR, emits hit/miss pulses.
// Optional build macro MOLE_PENALTY_EN: a wrong press while a mole is up ends the round as a miss.
module mole_round_controller #(
    parameter int unsigned N_HOLES    = 4,
    parameter int unsigned GAP_TICKS  = 200,
    parameter int unsigned MOLE_TICKS = 500,
    parameter int unsigned ROUNDS     = 30,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               tick,
    input  logic               start,
    input  logic [N_HOLES-1:0] buttons,
    output logic [N_HOLES-1:0] mole,
    output logic               whacked,
    output logic               miss,
    output logic               game_active,
    output logic               game_over,
    output logic [7:0]         round_count
);
    localparam int unsigned IDX_W     = (N_HOLES > 1) ? $clog2(N_HOLES) : 1;
    localparam int unsigned TIMER_W   = 16;
    localparam int unsigned LFSR_W    = 16;
    localparam int unsigned ROUND_W   = 8;
    localparam logic [TIMER_W-1:0] GAP_LAST  = TIMER_W'(GAP_TICKS - 1);
    localparam logic [TIMER_W-1:0] MOLE_LAST = TIMER_W'(MOLE_TICKS - 1);
    localparam logic [ROUND_W-1:0] ROUNDS_C  = ROUND_W'(ROUNDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        UP   = 2'd2,
        OVER = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [LFSR_W-1:0]    lfsr_q, lfsr_d;
    logic [N_HOLES-1:0]   buttons_q;
    logic [N_HOLES-1:0]   mole_q, mole_d;
    logic                 whacked_q, whacked_d;
    logic                 miss_q, miss_d;
    logic                 active_q, active_d;
    logic                 over_q, over_d;
    logic [ROUND_W-1:0]   round_q, round_d;

    logic [N_HOLES-1:0]   press;
    logic [N_HOLES-1:0]   hole_onehot;
    logic                 hit;
    logic                 wrong;
    logic                 end_round;
    logic [ROUND_W-1:0]   round_inc;

    // Fibonacci LFSR, taps 16,14,13,11; free-running so hole choice depends on start timing
    assign lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    assign press     = buttons & ~buttons_q;
    assign hit       = |(press & mole_q);
    assign wrong     = |(press & ~mole_q);
    assign round_inc = round_q + ROUND_W'(1);

    always_comb begin
        hole_onehot = '0;
        for (int unsigned i = 0; i < N_HOLES; i++) begin
            hole_onehot[i] = (lfsr_q[IDX_W-1:0] == IDX_W'(i));
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        mole_d    = mole_q;
        round_d   = round_q;
        whacked_d = 1'b0;
        miss_d    = 1'b0;
        end_round = 1'b0;

        case (state_q)
            IDLE: begin
                mole_d = '0;
                if (start) begin
                    state_d = GAP;
                    round_d = '0;
                    timer_d = '0;
                end
            end
            GAP: begin
                if (tick) begin
                    if (timer_q == GAP_LAST) begin
                        state_d = UP;
                        mole_d  = hole_onehot;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
            end
            UP: begin
`ifdef MOLE_PENALTY_EN
                // A wrong press outranks a simultaneous correct one
                if (wrong) begin
                    miss_d    = 1'b1;
                    end_round = 1'b1;
                end else if (hit) begin
`else
                if (hit) begin
`endif
                    whacked_d = 1'b1;
                    end_round = 1'b1;
                end else if (tick) begin
                    if (timer_q == MOLE_LAST) begin
                        miss_d    = 1'b1;
                        end_round = 1'b1;
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end

                if (end_round) begin
                    mole_d  = '0;
                    timer_d = '0;
                    round_d = round_inc;
                    state_d = (round_inc == ROUNDS_C) ? OVER : GAP;
                end
            end
            OVER: begin
                mole_d = '0;
                if (start) begin
                    state_d = GAP;
                    round_d = '0;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                mole_d  = '0;
            end
        endcase

        active_d = (state_d == GAP) || (state_d == UP);
        over_d   = (state_d == OVER);
    end

    // Wrong presses are unused in the default build; keep the signal referenced
    logic unused_wrong;
    assign unused_wrong = wrong;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            lfsr_q    <= LFSR_SEED;
            buttons_q <= '0;
            mole_q    <= '0;
            whacked_q <= 1'b0;
            miss_q    <= 1'b0;
            active_q  <= 1'b0;
            over_q    <= 1'b0;
            round_q   <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            lfsr_q    <= lfsr_d;
            buttons_q <= buttons;
            mole_q    <= mole_d;
            whacked_q <= whacked_d;
            miss_q    <= miss_d;
            active_q  <= active_d;
            over_q    <= over_d;
            round_q   <= round_d;
        end
    end

    assign mole        = mole_q;
    assign whacked     = whacked_q;
    assign miss        = miss_q;
    assign game_active = active_q;
    assign game_over   = over_q;
    assign round_count = round_q;

endmodule

// File: tb/tb_mole_round_controller.sv
// Self-checking bench for mole_round_controller (N_HOLES=4, GAP_TICKS=2, MOLE_TICKS=3, ROUNDS=2, tick high).
module tb_mole_round_controller;
    localparam int unsigned N = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic         tick;
    logic         start;
    logic [N-1:0] buttons;
    logic [N-1:0] mole;
    logic         whacked;
    logic         miss;
    logic         game_active;
    logic         game_over;
    logic [7:0]   round_count;

    int checks = 0;
    int errors = 0;

    // Expected pulse outcome: {whacked, miss, round_count}
    logic [9:0] sb[$];

    logic [15:0] m_lfsr;
    logic [15:0] m_lfsr_prev;

    mole_round_controller #(
        .N_HOLES   (4),
        .GAP_TICKS (2),
        .MOLE_TICKS(3),
        .ROUNDS    (2),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .tick       (tick),
        .start      (start),
        .buttons    (buttons),
        .mole       (mole),
        .whacked    (whacked),
        .miss       (miss),
        .game_active(game_active),
        .game_over  (game_over),
        .round_count(round_count)
    );

    always #5 clock = ~clock;

    // Reference LFSR; m_lfsr_prev is the value the DUT used at the most recent edge
    always @(posedge clock) begin
        m_lfsr_prev <= m_lfsr;
        if (!reset) m_lfsr <= 16'hACE1;
        else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    // Scoreboard: every whacked/miss pulse must match the next queued outcome
    always @(posedge clock) begin
        #1;
        if (whacked || miss) begin
            checks++;
            if (whacked && miss) begin
                errors++;
                $display("FAIL pulse_exclusive whacked=%0b miss=%0b expected at most one", whacked, miss);
            end else if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse whacked=%0b miss=%0b round=%0d expected none", whacked, miss, round_count);
            end else begin
                logic [9:0] exp_o;
                exp_o = sb.pop_front();
                if ({whacked, miss, round_count} !== exp_o) begin
                    errors++;
                    $display("FAIL outcome got w=%0b m=%0b rc=%0d expected w=%0b m=%0b rc=%0d",
                             whacked, miss, round_count, exp_o[9], exp_o[8], exp_o[7:0]);
                end
            end
        end
    end

    function automatic logic [N-1:0] onehot_of(input logic [15:0] l);
        logic [N-1:0] r;
        r = '0;
        r[l[1:0]] = 1'b1;
        return r;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; tick = 1'b1; buttons = '0;
        step(); step();
        checks++;
        if ({mole, whacked, miss, game_active, game_over, round_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got mole=%0h w=%0b m=%0b act=%0b over=%0b rc=%0d expected all 0",
                     mole, whacked, miss, game_active, game_over, round_count);
        end
        reset = 1'b1;
        step(); step();
        checks++;
        if ({game_active, mole} !== '0) begin
            errors++;
            $display("FAIL idle_hold got act=%0b mole=%0h expected 0 0", game_active, mole);
        end
    endtask

    task automatic test_start_hit();
        logic [N-1:0] e1, e2;
        start = 1'b1; step(); start = 1'b0;
        checks++;
        if ({game_active, game_over, mole, round_count} !== {1'b1, 1'b0, 4'h0, 8'd0}) begin
            errors++;
            $display("FAIL start_active got act=%0b over=%0b mole=%0h rc=%0d expected 1 0 0 0",
                     game_active, game_over, mole, round_count);
        end
        step();
        checks++;
        if (mole !== '0) begin errors++; $display("FAIL gap_no_mole got=%0h expected 0", mole); end
        step();
        e1 = onehot_of(m_lfsr_prev);
        checks++;
        if (mole !== e1 || !$onehot(mole)) begin
            errors++; $display("FAIL mole_appear got=%0h expected %0h", mole, e1);
        end
        step();
        checks++;
        if (mole !== e1) begin errors++; $display("FAIL mole_still_up got=%0h expected %0h", mole, e1); end
        buttons = e1;
        sb.push_back({1'b1, 1'b0, 8'd1});
        step();
        checks++;
        if ({whacked, mole, round_count, game_active} !== {1'b1, 4'h0, 8'd1, 1'b1}) begin
            errors++;
            $display("FAIL hit got w=%0b mole=%0h rc=%0d act=%0b expected 1 0 1 1", whacked, mole, round_count, game_active);
        end
        buttons = '0;
        step();
        checks++;
        if ({whacked, mole} !== {1'b0, 4'h0}) begin
            errors++; $display("FAIL hit_one_cycle got w=%0b mole=%0h expected 0 0", whacked, mole);
        end
        step();
        e2 = onehot_of(m_lfsr_prev);
        checks++;
        if (mole !== e2) begin errors++; $display("FAIL next_mole got=%0h expected %0h", mole, e2); end
    endtask

    task automatic test_miss_over();
        logic [N-1:0] e;
        e = mole;
        sb.push_back({1'b0, 1'b1, 8'd2});
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({mole, miss} !== {e, 1'b0}) begin
                errors++; $display("FAIL mole_lifetime cyc=%0d got mole=%0h miss=%0b expected %0h 0", i, mole, miss, e);
            end
        end
        step();
        checks++;
        if ({miss, whacked, mole, round_count, game_over, game_active} !== {1'b1, 1'b0, 4'h0, 8'd2, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL expire_over got m=%0b w=%0b mole=%0h rc=%0d over=%0b act=%0b expected 1 0 0 2 1 0",
                     miss, whacked, mole, round_count, game_over, game_active);
        end
        buttons = '1;
        step();
        checks++;
        if ({miss, round_count, game_over} !== {1'b0, 8'd2, 1'b1}) begin
            errors++; $display("FAIL over_hold got m=%0b rc=%0d over=%0b expected 0 2 1", miss, round_count, game_over);
        end
        buttons = '0;
        step();
        checks++;
        if ({whacked, mole, round_count} !== {1'b0, 4'h0, 8'd2}) begin
            errors++; $display("FAIL over_ignore_press got w=%0b mole=%0h rc=%0d expected 0 0 2", whacked, mole, round_count);
        end
    endtask

    task automatic test_restart();
        start = 1'b1; step(); start = 1'b0;
        checks++;
        if ({round_count, game_active, game_over} !== {8'd0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL restart got rc=%0d act=%0b over=%0b expected 0 1 0", round_count, game_active, game_over);
        end
        step(); step();
    endtask

    task automatic test_hold_and_expiry_hit();
        logic [N-1:0] e3, e4;
        e3 = onehot_of(m_lfsr_prev);
        checks++;
        if (mole !== e3) begin errors++; $display("FAIL hold_mole got=%0h expected %0h", mole, e3); end
        buttons = e3;
        sb.push_back({1'b1, 1'b0, 8'd1});
        step();
        checks++;
        if ({whacked, round_count} !== {1'b1, 8'd1}) begin
            errors++; $display("FAIL hold_hit got w=%0b rc=%0d expected 1 1", whacked, round_count);
        end
        step();
        checks++;
        if (whacked !== 1'b0) begin errors++; $display("FAIL hold_single got w=%0b expected 0", whacked); end
        step();
        e4 = onehot_of(m_lfsr_prev);
        checks++;
        if ({whacked, mole} !== {1'b0, e4}) begin
            errors++; $display("FAIL hold_next got w=%0b mole=%0h expected 0 %0h", whacked, mole, e4);
        end
        buttons = '0;
        step(); step();
        checks++;
        if (mole !== e4) begin errors++; $display("FAIL expiry_up got=%0h expected %0h", mole, e4); end
        buttons = e4;
        sb.push_back({1'b1, 1'b0, 8'd2});
        step();
        checks++;
        if ({whacked, miss, round_count, game_over} !== {1'b1, 1'b0, 8'd2, 1'b1}) begin
            errors++; $display("FAIL expiry_hit got w=%0b m=%0b rc=%0d over=%0b expected 1 0 2 1",
                               whacked, miss, round_count, game_over);
        end
        buttons = '0;
        step();
    endtask

    task automatic test_wrong_and_correct();
        logic [N-1:0] e5, other;
        start = 1'b1; step(); start = 1'b0;
        step(); step();
        e5 = onehot_of(m_lfsr_prev);
        checks++;
        if (mole !== e5) begin errors++; $display("FAIL mixed_mole got=%0h expected %0h", mole, e5); end
        other = {e5[N-2:0], e5[N-1]};
        buttons = e5 | other;
`ifdef MOLE_PENALTY_EN
        sb.push_back({1'b0, 1'b1, 8'd1});
        step();
        checks++;
        if ({whacked, miss, round_count, mole} !== {1'b0, 1'b1, 8'd1, 4'h0}) begin
            errors++; $display("FAIL mixed_press got w=%0b m=%0b rc=%0d mole=%0h expected 0 1 1 0", whacked, miss, round_count, mole);
        end
`else
        sb.push_back({1'b1, 1'b0, 8'd1});
        step();
        checks++;
        if ({whacked, miss, round_count, mole} !== {1'b1, 1'b0, 8'd1, 4'h0}) begin
            errors++; $display("FAIL mixed_press got w=%0b m=%0b rc=%0d mole=%0h expected 1 0 1 0", whacked, miss, round_count, mole);
        end
`endif
        buttons = '0;
    endtask

    task automatic test_reset_mid_up();
        logic [N-1:0] e6;
        step(); step();
        e6 = onehot_of(m_lfsr_prev);
        checks++;
        if (mole !== e6) begin errors++; $display("FAIL abort_mole got=%0h expected %0h", mole, e6); end
        step();
        reset = 1'b0;
        step();
        checks++;
        if ({mole, game_active, round_count, whacked, miss} !== '0) begin
            errors++; $display("FAIL abort_reset got mole=%0h act=%0b rc=%0d w=%0b m=%0b expected all 0",
                               mole, game_active, round_count, whacked, miss);
        end
        reset = 1'b1;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if ({mole, game_active, game_over, whacked, miss} !== '0) begin
            errors++; $display("FAIL abort_idle got mole=%0h act=%0b over=%0b w=%0b m=%0b expected all 0",
                               mole, game_active, game_over, whacked, miss);
        end
    endtask

    initial begin
        test_reset();
        test_start_hit();
        test_miss_over();
        test_restart();
        test_hold_and_expiry_hit();
        test_wrong_and_correct();
        test_reset_mid_up();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
